// File: rtl/npc_fetch_pc.sv
// Purpose : F-stage fetch PC with branch/jump/jr target formation and a one-deep stalled-redirect buffer.
// Latency : one clk edge from an unstalled redirect request to the new f_pc (delay slot is never squashed).
// Backpr. : stall freezes f_pc; one redirect seen under stall is buffered, a further one is dropped (sticky flag).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 hold the F-stage PC this cycle
//   br_taken/br_offset_sl2  taken branch pulse and pre-shifted sign-extended offset
//   jump/j_index          j/jal pulse and 26-bit instr_index
//   jr/jr_target          jr/jalr pulse and forwarded rs value
//   d_pc                  PC of the D-stage control-transfer instruction
//   f_pc                  fetch PC / instruction-memory address
//   redirect_pending      a buffered redirect waits for the stall to release
//   redirect_overflow     sticky: a redirect was dropped while one was already buffered
//   fetch_oob             f_pc lies outside IM_BASE..IM_BASE+IM_SIZE-1
//   fetch_adel            (NPC_ALIGN_CHECK_EN only) f_pc is not word aligned
//
// Build option: define NPC_ALIGN_CHECK_EN to keep misaligned jr targets and expose fetch_adel;
// otherwise jr targets are forced to word alignment.

module npc_fetch_pc #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_offset_sl2,
   input  logic        jump,
   input  logic [25:0] j_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic [31:0] d_pc,
   output logic [31:0] f_pc,
   output logic        redirect_pending,
   output logic        redirect_overflow,
`ifdef NPC_ALIGN_CHECK_EN
   output logic        fetch_adel,
`endif
   output logic        fetch_oob
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] pend_target_q, pend_target_nxt;
   logic        overflow_q, overflow_nxt;

   // ------------------------------------------------------------------
   // Target formation
   // ------------------------------------------------------------------
   logic [31:0] d_pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] jr_tgt;
   logic [31:0] target;
   logic        req;

   assign d_pc_plus4 = d_pc + 32'd4;
   assign br_tgt     = d_pc_plus4 + br_offset_sl2;
   assign j_tgt      = {d_pc_plus4[31:28], j_index, 2'b00};

`ifdef NPC_ALIGN_CHECK_EN
   // Misaligned jr targets are fetched as-is; the fault is reported via fetch_adel.
   assign jr_tgt = jr_target;
`else
   // Without the alignment fault path the low two bits are simply discarded.
   // Since this feeds both the direct and the buffered path, both see the aligned value.
   assign jr_tgt = jr_target & 32'hFFFF_FFFC;
`endif

   assign req = jr | jump | br_taken;

   // Priority: jr > jump > br_taken.
   always_comb begin
      target = br_tgt;
      if (jr) begin
         target = jr_tgt;
      end else if (jump) begin
         target = j_tgt;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pc_q          <= RESET_PC;
         pend_target_q <= 32'h0000_0000;
         overflow_q    <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc_q          <= pc_nxt;
         pend_target_q <= pend_target_nxt;
         overflow_q    <= overflow_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state / datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc_q;
      pend_target_nxt = pend_target_q;
      overflow_nxt    = overflow_q;

      case (state)
         IDLE: begin
            if (!stall) begin
               // f_pc + 4 wraps naturally at 2^32.
               pc_nxt = req ? target : (pc_q + 32'd4);
            end else if (req) begin
               pend_target_nxt = target;
               state_nxt       = PEND;
            end
         end

         PEND: begin
            if (!stall) begin
               // The buffered redirect is older, so it is applied first; a
               // request arriving on the same edge takes over the buffer.
               pc_nxt = pend_target_q;
               if (req) begin
                  pend_target_nxt = target;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (req) begin
               // Buffer is full: drop the new redirect and latch the error.
               overflow_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   logic [32:0] im_limit;

   // Computed in 33 bits so a region touching the top of the address space
   // does not wrap the upper bound to zero.
   assign im_limit = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

   assign f_pc              = pc_q;
   assign redirect_pending  = (state == PEND);
   assign redirect_overflow = overflow_q;
   assign fetch_oob         = (pc_q < IM_BASE) || ({1'b0, pc_q} >= im_limit);

`ifdef NPC_ALIGN_CHECK_EN
   assign fetch_adel = (pc_q[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_npc_fetch_pc.sv
module tb_npc_fetch_pc;

   logic        clk = 1'b0;
   logic        reset, stall, br_taken, jump, jr;
   logic [31:0] br_offset_sl2, jr_target, d_pc;
   logic [25:0] j_index;
   logic [31:0] f_pc;
   logic        redirect_pending, redirect_overflow, fetch_oob;
`ifdef NPC_ALIGN_CHECK_EN
   logic        fetch_adel;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   npc_fetch_pc dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .br_taken          (br_taken),
      .br_offset_sl2     (br_offset_sl2),
      .jump              (jump),
      .j_index           (j_index),
      .jr                (jr),
      .jr_target         (jr_target),
      .d_pc              (d_pc),
      .f_pc              (f_pc),
      .redirect_pending  (redirect_pending),
      .redirect_overflow (redirect_overflow),
`ifdef NPC_ALIGN_CHECK_EN
      .fetch_adel        (fetch_adel),
`endif
      .fetch_oob         (fetch_oob)
   );

   // Reference model: architectural PC plus a queue of waiting redirects
   // that may never hold more than one entry.
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   logic        m_ovf;

   function automatic logic [31:0] ref_target(input logic jrr, input logic jp,
                                              input logic [31:0] jt, input logic [25:0] ji,
                                              input logic [31:0] dp, input logic [31:0] off);
      logic [31:0] p4;
      p4 = dp + 32'd4;
      if (jrr) begin
`ifdef NPC_ALIGN_CHECK_EN
         return jt;
`else
         return {jt[31:2], 2'b00};
`endif
      end
      if (jp) return {p4[31:28], ji, 2'b00};
      return p4 + off;
   endfunction

   task automatic model_edge();
      logic        rq;
      logic [31:0] t;
      rq = jr | jump | br_taken;
      t  = ref_target(jr, jump, jr_target, j_index, d_pc, br_offset_sl2);
      if (reset) begin
         m_pc  = 32'h3000;
         m_q.delete();
         m_ovf = 1'b0;
      end else if (!stall) begin
         if (m_q.size() != 0) begin
            m_pc = m_q.pop_front();
            if (rq) m_q.push_back(t);
         end else begin
            m_pc = rq ? t : m_pc + 32'd4;
         end
      end else if (rq) begin
         if (m_q.size() == 0) m_q.push_back(t);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic oob;
      oob = (m_pc < 32'h3000) || (m_pc >= 32'h7000);
      chk({tag, ".f_pc"}, f_pc, m_pc);
      chk({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, m_q.size() != 0});
      chk({tag, ".overflow"}, {31'd0, redirect_overflow}, {31'd0, m_ovf});
      chk({tag, ".oob"}, {31'd0, fetch_oob}, {31'd0, oob});
`ifdef NPC_ALIGN_CHECK_EN
      chk({tag, ".adel"}, {31'd0, fetch_adel}, {31'd0, m_pc[1:0] != 2'b00});
`endif
   endtask

   task automatic clear_req();
      br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
   endtask

   // Inputs are already driven (mid-cycle); advance one edge and compare.
   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_model(tag);
      clear_req();
   endtask

   logic [31:0] frozen;

   initial begin
      reset = 1'b1; stall = 1'b0; clear_req();
      br_offset_sl2 = '0; jr_target = '0; d_pc = '0; j_index = '0;
      m_pc = '0; m_ovf = 1'b0;

      // 1. reset then sequential fetch
      step("rst0");
      step("rst1");
      chk("reset_pc", f_pc, 32'h3000);
      chk("reset_pend", {31'd0, redirect_pending}, 32'd0);
      chk("reset_ovf", {31'd0, redirect_overflow}, 32'd0);
      reset = 1'b0;
      step("seq1"); chk("seq_3004", f_pc, 32'h3004);
      step("seq2"); chk("seq_3008", f_pc, 32'h3008);
      step("seq3"); chk("seq_300c", f_pc, 32'h300C);
      chk("seq_oob", {31'd0, fetch_oob}, 32'd0);

      // 2. forward and backward branch
      d_pc = 32'h3004; br_offset_sl2 = 32'h0000_000C; br_taken = 1'b1;
      step("brf"); chk("br_fwd", f_pc, 32'h3014);
      d_pc = 32'h3010; br_offset_sl2 = 32'hFFFF_FFF8; br_taken = 1'b1;
      step("brb"); chk("br_bwd", f_pc, 32'h300C);

      // 3. jump, then jr beating jump
      d_pc = 32'h3020; j_index = 26'h000_0C10; jump = 1'b1;
      step("j"); chk("jump", f_pc, 32'h3040);
      jump = 1'b1; jr = 1'b1; jr_target = 32'h3100;
      step("jrj"); chk("jr_prio", f_pc, 32'h3100);

      // 4. branch under a 3-cycle stall is buffered
      frozen = f_pc;
      stall = 1'b1; d_pc = 32'h3000; br_offset_sl2 = 32'h0000_003C; br_taken = 1'b1;
      step("st1"); chk("st1_pc", f_pc, frozen); chk("st1_pend", {31'd0, redirect_pending}, 32'd1);
      step("st2"); chk("st2_pc", f_pc, frozen); chk("st2_pend", {31'd0, redirect_pending}, 32'd1);
      step("st3"); chk("st3_pc", f_pc, frozen);
      stall = 1'b0;
      step("rel"); chk("rel_pc", f_pc, 32'h3040); chk("rel_pend", {31'd0, redirect_pending}, 32'd0);

      // 5. overflow while pending, then reset clears it
      stall = 1'b1; br_taken = 1'b1; d_pc = 32'h3000; br_offset_sl2 = 32'h0000_0010;
      step("ov_pend");
      jump = 1'b1; d_pc = 32'h3020; j_index = 26'h000_0C80;
      step("ov_drop"); chk("ov_flag", {31'd0, redirect_overflow}, 32'd1);
      stall = 1'b0;
      step("ov_rel"); chk("ov_keep_target", f_pc, 32'h3014);
      chk("ov_sticky", {31'd0, redirect_overflow}, 32'd1);
      stall = 1'b1; br_taken = 1'b1;
      step("ov_pend2");
      reset = 1'b1;
      step("ov_rst");
      chk("ov_rst_flag", {31'd0, redirect_overflow}, 32'd0);
      chk("ov_rst_pc", f_pc, 32'h3000);
      chk("ov_rst_pend", {31'd0, redirect_pending}, 32'd0);
      reset = 1'b0; stall = 1'b0;

      // 6. bounds and alignment
      jr = 1'b1; jr_target = 32'h7000;
      step("oob"); chk("oob_hi", {31'd0, fetch_oob}, 32'd1);
      jr = 1'b1; jr_target = 32'h3002;
      step("mis");
`ifdef NPC_ALIGN_CHECK_EN
      chk("mis_pc", f_pc, 32'h3002);
      chk("mis_adel", {31'd0, fetch_adel}, 32'd1);
`else
      chk("mis_pc", f_pc, 32'h3000);
`endif
      // wrap-around of sequential fetch
      jr = 1'b1; jr_target = 32'hFFFF_FFFC;
      step("wrap0");
      step("wrap1"); chk("wrap_pc", f_pc, 32'h0000_0000);
      chk("wrap_oob", {31'd0, fetch_oob}, 32'd1);

      // randomized run against the model
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 63) == 0);
         stall         = ($urandom_range(0, 2) == 0);
         br_taken      = ($urandom_range(0, 3) == 0);
         jump          = ($urandom_range(0, 5) == 0);
         jr            = ($urandom_range(0, 5) == 0);
         d_pc          = 32'h3000 + ($urandom_range(0, 32'h4FFF) & 32'hFFFF_FFFC);
         br_offset_sl2 = ($urandom_range(0, 1) != 0) ? {{20{1'b0}}, $urandom_range(0, 4095) & 12'hFFC}
                                                       : (32'hFFFF_F000 | ($urandom_range(0, 4095) & 32'hFFC));
         j_index       = 26'($urandom);
         jr_target     = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + $urandom_range(0, 32'h3FFF);
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
